// File: rtl/led_bar_animator.sv
// led_bar_animator: drives NUM_LEDS discrete LEDs from a binary level value.
// Modes: 00 bar, 01 single dot, 10 blinking bar, 11 animated fill (one LED
// per prescaler tick). An internal prescaler supplies the blink/step rate.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   value_in  requested level (0 = all LEDs off)
//   load      one-cycle strobe capturing value_in as the new target
//   mode      display mode select
//   leds      registered LED drive, bit 0 = lowest LED
//   busy      animated level still differs from target (mode 11 only)
//   overflow  current target was saturated to NUM_LEDS
module led_bar_animator #(
    parameter int unsigned NUM_LEDS = 9,
    parameter int unsigned VAL_W    = 4,
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [VAL_W-1:0]    value_in,
    input  logic                load,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                busy,
    output logic                overflow
);

    localparam int unsigned LVL_W = $clog2(NUM_LEDS + 1);
    localparam int unsigned PRE_W = $clog2(TICK_DIV);

    localparam logic [1:0] MODE_BAR   = 2'b00;
    localparam logic [1:0] MODE_DOT   = 2'b01;
    localparam logic [1:0] MODE_BLINK = 2'b10;
    localparam logic [1:0] MODE_ANIM  = 2'b11;

    logic [LVL_W-1:0]    target_q, target_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic                blink_q, blink_d;
    logic                overflow_q, overflow_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                busy_q, busy_d;

    logic                tick_c;
    logic [NUM_LEDS-1:0] bar_c;
    logic [NUM_LEDS-1:0] dot_c;

    // Free-running prescaler and blink phase
    always_comb begin
        tick_c  = (presc_q == PRE_W'(TICK_DIV - 1));
        presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
        blink_d = tick_c ? ~blink_q : blink_q;
    end

    // Target capture with saturation to NUM_LEDS
    always_comb begin
        target_d   = target_q;
        overflow_d = overflow_q;
        if (load) begin
            overflow_d = (32'(value_in) > NUM_LEDS);
            target_d   = overflow_d ? LVL_W'(NUM_LEDS) : LVL_W'(value_in);
        end
    end

    // Level tracks target directly, or steps one LED per tick in mode 11.
    // The step compares against the registered target, so a load landing on
    // a tick only steers from the following tick.
    always_comb begin
        level_d = level_q;
        if (mode != MODE_ANIM) begin
            level_d = target_q;
        end else if (tick_c) begin
            if (level_q < target_q) begin
                level_d = level_q + LVL_W'(1);
            end else if (level_q > target_q) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    // LED pattern decode from the registered level
    always_comb begin
        bar_c = '0;
        dot_c = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            bar_c[i] = (32'(level_q) > i);
            dot_c[i] = (32'(level_q) == i + 1);
        end

        leds_d = '0;
        case (mode)
            MODE_BAR:   leds_d = bar_c;
            MODE_DOT:   leds_d = dot_c;
            MODE_BLINK: leds_d = blink_q ? bar_c : '0;
            MODE_ANIM:  leds_d = bar_c;
            default:    leds_d = '0;
        endcase

        busy_d = (mode == MODE_ANIM) && (level_q != target_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_q   <= '0;
            level_q    <= '0;
            presc_q    <= '0;
            blink_q    <= 1'b1;
            overflow_q <= 1'b0;
            leds_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            target_q   <= target_d;
            level_q    <= level_d;
            presc_q    <= presc_d;
            blink_q    <= blink_d;
            overflow_q <= overflow_d;
            leds_q     <= leds_d;
            busy_q     <= busy_d;
        end
    end

    assign leds     = leds_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_led_bar_animator.sv
// tb_led_bar_animator: scoreboard bench for led_bar_animator with
// NUM_LEDS=9, VAL_W=4, TICK_DIV=4. Expected observations are queued with the
// clock edge after which they must hold; a negedge monitor retires them.
module tb_led_bar_animator;

    localparam int unsigned NL  = 9;
    localparam int unsigned VW  = 4;
    localparam int unsigned DIV = 4;

    localparam int K_LEDS = 0;
    localparam int K_BUSY = 1;
    localparam int K_OVF  = 2;

    typedef struct {
        int    at;
        int    kind;
        int    val;
        string tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [VW-1:0] value_in;
    logic          load;
    logic [1:0]    mode;
    logic [NL-1:0] leds;
    logic          busy;
    logic          overflow;

    int   ecnt = 0;
    int   rel  = 0;
    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb[$];

    led_bar_animator #(.NUM_LEDS(NL), .VAL_W(VW), .TICK_DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value_in (value_in),
        .load     (load),
        .mode     (mode),
        .leds     (leds),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ecnt);
        end
    endtask

    // Retire every expectation due at the current edge; overdue ones are misses
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at < ecnt) begin
                check_eq({sb[i].tag, "_missed"}, ecnt, sb[i].at);
                sb.delete(i);
            end else if (sb[i].at == ecnt) begin
                case (sb[i].kind)
                    K_LEDS:  check_eq(sb[i].tag, int'(leds), sb[i].val);
                    K_BUSY:  check_eq(sb[i].tag, int'(busy), sb[i].val);
                    default: check_eq(sb[i].tag, int'(overflow), sb[i].val);
                endcase
                sb.delete(i);
            end
        end
    end

    function automatic int bar(input int n);
        return (1 << n) - 1;
    endfunction

    // Blink phase after edge y: starts at 1, toggles on each tick edge rel+4k
    function automatic int blink_after(input int y);
        if (y < rel) return 1;
        return (((y - rel) / DIV) % 2 == 0) ? 1 : 0;
    endfunction

    function automatic int next_tick(input int x);
        if (x < rel) return rel + DIV;
        return rel + DIV * ((x - rel) / DIV + 1);
    endfunction

    task automatic push(input int at, input int kind, input int val, input string tag);
        exp_t e;
        e.at = at; e.kind = kind; e.val = val; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle load; returns the edge that captured it
    task automatic do_load(input int v, input logic [1:0] m, output int e);
        value_in = VW'(v);
        mode     = m;
        load     = 1'b1;
        step(1);
        load = 1'b0;
        e    = ecnt;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step(1);
            n++;
        end
        check_eq("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int e, t, m;
        rst_n = 1'b0; value_in = '0; load = 1'b0; mode = 2'b00;

        // Reset held three edges; outputs clear from the first reset edge
        for (int k = 1; k <= 4; k++) begin
            push(k, K_LEDS, 0, "rst_leds");
            push(k, K_BUSY, 0, "rst_busy");
            push(k, K_OVF,  0, "rst_ovf");
        end
        step(3);
        rst_n = 1'b1;
        rel   = ecnt;
        drain(20);

        // Bar: exactly two edges from load to pattern
        do_load(5, 2'b00, e);
        push(e,     K_OVF,  0,      "bar_ovf");
        push(e + 1, K_LEDS, 0,      "bar5_early");
        push(e + 2, K_LEDS, 'h01F,  "bar5");
        drain(20);
        do_load(0, 2'b00, e);
        push(e + 2, K_LEDS, 0, "bar0");
        drain(20);

        // Dot
        do_load(3, 2'b01, e);
        push(e + 2, K_LEDS, 'h004, "dot3");
        drain(20);
        do_load(9, 2'b01, e);
        push(e + 2, K_LEDS, 'h100, "dot9");
        drain(20);

        // Blink: full bar gated by phase, 4 cycles per half period
        do_load(9, 2'b10, e);
        for (int k = 2; k < 12; k++)
            push(e + k, K_LEDS, blink_after(e + k - 1) ? 'h1FF : 0, "blink");
        drain(30);

        // Back to zero, then animated fill 0 -> 4
        do_load(0, 2'b00, e);
        push(e + 2, K_LEDS, 0, "anim_pre");
        drain(20);
        do_load(4, 2'b11, e);
        push(e + 1, K_BUSY, 1, "fill_busy_start");
        t = next_tick(e);
        for (int k = 1; k <= 4; k++) begin
            push(t + 1, K_LEDS, bar(k), "fill_step");
            if (k == 4) begin
                push(t,     K_BUSY, 1, "fill_busy_last");
                push(t + 1, K_BUSY, 0, "fill_busy_done");
                push(t + 5, K_LEDS, 'h00F, "fill_no_overshoot");
            end
            t += DIV;
        end
        drain(60);

        // Reload lower during animation: steps down 4 -> 1
        do_load(1, 2'b11, e);
        t = next_tick(e);
        for (int k = 3; k >= 1; k--) begin
            push(t + 1, K_LEDS, bar(k), "unfill_step");
            if (k == 1) begin
                push(t + 1, K_BUSY, 0, "unfill_busy_done");
                push(t + 5, K_LEDS, 'h001, "unfill_hold");
            end
            t += DIV;
        end
        drain(60);

        // Saturation
        do_load(12, 2'b00, e);
        push(e,     K_OVF,  1,     "sat_ovf");
        push(e + 2, K_LEDS, 'h1FF, "sat_leds");
        drain(20);
        do_load(3, 2'b00, e);
        push(e,     K_OVF,  0,     "sat_clear");
        push(e + 2, K_LEDS, 'h007, "three");
        drain(20);

        // Load landing on a tick: step uses the old target (3 = level, hold)
        while (((ecnt + 1 - rel) % DIV) != 0) step(1);
        do_load(6, 2'b11, e);
        push(e + 1, K_LEDS, 'h007, "ldtick_hold");
        push(e + 1, K_BUSY, 1,     "ldtick_busy");
        push(e + 3, K_LEDS, 'h007, "ldtick_hold2");
        push(e + 5, K_LEDS, 'h00F, "ldtick_step4");
        push(e + 9, K_LEDS, 'h01F, "ldtick_step5");
        drain(30);

        // Leave mode 11 mid-fill: level snaps to target 6, busy drops
        while (ecnt < e + 9) step(1);
        mode = 2'b00;
        m = ecnt + 1;
        push(m + 1, K_LEDS, 'h03F, "snap_leds");
        push(m + 1, K_BUSY, 0,     "snap_busy");
        drain(20);

        // Reset mid-fill clears everything on the reset edge
        do_load(12, 2'b11, e);
        push(e, K_OVF, 1, "fill9_ovf");
        t = next_tick(e);
        push(t + 1, K_LEDS, 'h07F, "fill9_step7");
        drain(30);
        rst_n = 1'b0;
        push(ecnt + 1, K_LEDS, 0, "midrst_leds");
        push(ecnt + 1, K_BUSY, 0, "midrst_busy");
        push(ecnt + 1, K_OVF,  0, "midrst_ovf");
        step(1);
        rst_n = 1'b1;
        push(ecnt + 6, K_LEDS, 0, "postrst_leds");
        push(ecnt + 6, K_BUSY, 0, "postrst_busy");
        drain(20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
